tcdm_mem_responder: RTL and testbench

- Responder (slave) end of the TCDM request/grant/r_valid protocol that the FC core's instruction and data ports drive as masters.
- Holds a single-port word-addressed memory with byte-enable writes and answers every granted request after a fixed, parameterised latency.
- Flags out-of-range accesses on r_opc.
- Serves as the L2-side model/private bank for FC-subsystem integration tests, and as a small private SRAM bank in synthesis.

---
 rtl/tcdm_mem_responder.sv | 104 ++++++++++
 tb/tb_tcdm_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_mem_responder.sv
// Purpose : TCDM responder with a single-port word memory, byte-enable writes and out-of-range flagging.
// Latency : LATENCY cycles from the grant edge to a one-cycle r_valid_o pulse, with responses in accept order.
// Backpres: gnt_o = req_i & ~stall_i & rst_ni. The response pipeline never stalls, so one accept per cycle is sustained.
//
// Ports:
//   clk_i, rst_ni         clock; synchronous active-low reset (memory contents are kept)
//   stall_i               forces gnt_o low (back-pressure injection)
//   req_i, add_i, wen_i   request valid, byte address, 0=write / 1=read
//   wdata_i, be_i         write data and byte enables (be_i ignored on reads)
//   gnt_o                 request accepted this cycle
//   r_valid_o, r_rdata_o  response strobe and read data (zero when no response)
//   r_opc_o               1 = address outside [BASE_ADDR, BASE_ADDR + DEPTH*4)
module tcdm_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        req_i,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        r_valid_o,
    output logic [31:0] r_rdata_o,
    output logic        r_opc_o
);

    localparam int          LAT  = int'(LATENCY);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("tcdm_mem_responder: LATENCY must be in 1..4");
    end
    if (DEPTH < 16 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tcdm_mem_responder: DEPTH must be a power of two in 16..65536");
    end

    logic            accept;
    logic            in_range;
    logic [31:0]     offset;
    logic [AW-1:0]   word_idx;
    logic [31:0]     mem [DEPTH];

    logic [LAT-1:0]  valid_q;
    logic [LAT-1:0]  opc_q;
    logic [31:0]     rdata_q [LAT];

    assign gnt_o  = req_i & ~stall_i & rst_ni;
    assign accept = req_i & gnt_o;

    // Checking the offset instead of add_i < BASE_ADDR + SPAN avoids a
    // 32-bit wrap when the window ends at the top of the address space.
    // The lower-bound test rejects addresses whose subtraction wraps.
    assign offset   = add_i - BASE_ADDR;
    assign in_range = (add_i >= BASE_ADDR) && (offset < SPAN);
    assign word_idx = offset[AW+1:2];

    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    // Memory has no reset. Only in-range granted writes touch it.
    always_ff @(posedge clk_i) begin
        if (accept && in_range && !wen_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response shift register. Idle stages carry zeros, so the output stage
    // is all-zero whenever no response is due. A write accepted on the
    // previous edge is already visible to a read on this edge, so
    // read-after-write returns the merged word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            opc_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= accept;
            opc_q[0]   <= accept & ~in_range;
            rdata_q[0] <= (accept && in_range && wen_i) ? mem[word_idx] : 32'h0;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                opc_q[i]   <= opc_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign r_valid_o = valid_q[LAT-1];
    assign r_opc_o   = opc_q[LAT-1];
    assign r_rdata_o = rdata_q[LAT-1];

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// Purpose : drives three responders (LATENCY 1, 3 and 4) from one request stream and checks them against a reference model.
// Latency : the expected response for an accept at edge e is due at edge e+L-1, unless a reset edge falls after e.
// Backpres: exercises stall_i while req_i is held and checks that request fields stay stable until the grant.
module tb_tcdm_mem_responder;

    localparam logic [31:0] BASE = 32'h1C00_0000;
    localparam longint      SPAN = 1024 * 4;

    logic        clk = 1'b0;
    logic        rst_n, stall, req, wen;
    logic [31:0] add, wdata;
    logic [3:0]  be;
    logic [2:0]  gnt, rv, op;
    logic [31:0] rd [3];

    always #5 clk = ~clk;

    tcdm_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h1C00_0000), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .be_i(be), .gnt_o(gnt[0]),
        .r_valid_o(rv[0]), .r_rdata_o(rd[0]), .r_opc_o(op[0]));
    tcdm_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h1C00_0000), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .be_i(be), .gnt_o(gnt[1]),
        .r_valid_o(rv[1]), .r_rdata_o(rd[1]), .r_opc_o(op[1]));
    tcdm_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h1C00_0000), .LATENCY(4)) u_l4 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .req_i(req), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .be_i(be), .gnt_o(gnt[2]),
        .r_valid_o(rv[2]), .r_rdata_o(rd[2]), .r_opc_o(op[2]));

    typedef struct packed {
        logic [31:0] rdata;
        logic        opc;
    } resp_t;

    int          lat [3];
    int          checks   = 0;
    int          errors   = 0;
    int          edge_n   = 0;
    int          last_rst = 0;
    resp_t       acc [int];         // accept edge -> response owed
    logic [31:0] mdl [int];         // word index -> contents
    logic        prev_held = 1'b0;  // previous cycle had req=1 with no grant
    logic [31:0] prev_add, prev_wdata;
    logic [4:0]  prev_ctl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return mdl[int'((a - BASE) >> 2)];
    endfunction

    task automatic model_accept();
        longint      a;
        int          idx;
        resp_t       r;
        logic [31:0] w;
        a   = longint'(add);
        idx = int'((add - BASE) >> 2);
        r   = '0;
        if (!(a >= longint'(BASE) && a < longint'(BASE) + SPAN)) begin
            r.opc = 1'b1;
        end else if (!wen) begin
            w = mdl.exists(idx) ? mdl[idx] : 32'hx;
            for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
            mdl[idx] = w;
        end else begin
            r.rdata = mdl.exists(idx) ? mdl[idx] : 32'hx;
        end
        acc[edge_n] = r;
    endtask

    // Inputs are set at a falling edge. One clock is run, and then grant,
    // protocol and response checks are made away from the rising edge.
    task automatic step();
        int    e;
        logic  expv;
        resp_t exp;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("gnt L%0d", lat[i]), {31'b0, gnt[i]}, {31'b0, req & ~stall & rst_n});
        if (prev_held && req) begin
            chk("held add", add, prev_add);
            chk("held wdata", wdata, prev_wdata);
            chk("held wen/be", {27'b0, wen, be}, {27'b0, prev_ctl});
        end
        prev_held  = req & (stall | ~rst_n);
        prev_add   = add;
        prev_wdata = wdata;
        prev_ctl   = {wen, be};
        @(posedge clk);
        edge_n++;
        if (!rst_n) last_rst = edge_n;
        else if (req && !stall) model_accept();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e    = edge_n - lat[i] + 1;
            expv = acc.exists(e) && (e > last_rst);
            exp  = expv ? acc[e] : '0;
            chk($sformatf("r_valid L%0d", lat[i]), {31'b0, rv[i]}, {31'b0, expv});
            chk($sformatf("r_rdata L%0d", lat[i]), rd[i], exp.rdata);
            chk($sformatf("r_opc L%0d", lat[i]), {31'b0, op[i]}, {31'b0, exp.opc});
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; wen = 1'b0; add = a; wdata = d; be = b;
        step();
        req = 1'b0;
    endtask

    task automatic rdw(input logic [31:0] a);
        req = 1'b1; wen = 1'b1; add = a; wdata = $urandom; be = 4'($urandom_range(0, 15));
        step();
        req = 1'b0;
    endtask

    task automatic idle();
        req = 1'b0;
        step();
    endtask

    initial begin
        int sel;
        lat[0] = 1; lat[1] = 3; lat[2] = 4;
        rst_n = 1'b0; stall = 1'b0; req = 1'b0; wen = 1'b1;
        add = '0; wdata = '0; be = '0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        chk("reset r_valid", {29'b0, rv}, 32'h0);
        chk("reset r_opc", {29'b0, op}, 32'h0);

        // Write then read back at LATENCY 1.
        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        chk("wr resp valid L1", {31'b0, rv[0]}, 32'h1);
        chk("wr resp rdata L1", rd[0], 32'h0);
        rdw(BASE + 32'h10);
        chk("rd DEADBEEF L1", rd[0], 32'hDEAD_BEEF);

        // Fill words 0..15 and the last in-range word.
        for (int i = 0; i < 16; i++) wr(BASE + 32'(i * 4), $urandom, 4'hF);
        wr(BASE + 32'hFFC, 32'h0BAD_F00D, 4'hF);

        // Byte enables and a no-op write.
        wr(BASE + 32'h20, 32'h1122_3344, 4'hF);
        wr(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
        rdw(BASE + 32'h20);
        chk("be merge L1", rd[0], 32'h11BB_33DD);
        wr(BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000);
        chk("be0 resp valid L1", {31'b0, rv[0]}, 32'h1);
        rdw(BASE + 32'h22);
        chk("be0 unchanged L1", rd[0], 32'h11BB_33DD);

        // Out-of-range accesses and the top in-range word.
        rdw(BASE + 32'h1000);
        chk("oor rd opc L1", {31'b0, op[0]}, 32'h1);
        chk("oor rd rdata L1", rd[0], 32'h0);
        wr(BASE - 32'h4, 32'h5555_5555, 4'hF);
        chk("oor wr opc L1", {31'b0, op[0]}, 32'h1);
        rdw(BASE + 32'hFFC);
        chk("top word L1", rd[0], 32'h0BAD_F00D);
        rdw(BASE);
        chk("word0 after oor wr", rd[0], word_of(BASE));

        // Back-to-back read stream, then a drain.
        for (int i = 0; i < 8; i++) begin
            rdw(BASE + 32'(i * 4));
            if (i == 2) chk("stream first L3", rd[1], word_of(BASE));
        end
        for (int i = 0; i < 5; i++) idle();

        // Request held under stall for three cycles, then granted twice.
        req = 1'b1; wen = 1'b1; add = BASE + 32'h4; wdata = 32'h0; be = 4'h0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0;
        step();
        step();
        req = 1'b0;
        for (int i = 0; i < 5; i++) idle();

        // Reset while two reads are in flight.
        rdw(BASE + 32'h8);
        rdw(BASE + 32'hC);
        idle();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("post-reset r_valid L4", {31'b0, rv[2]}, 32'h0);
        for (int i = 0; i < 5; i++) idle();
        rdw(BASE + 32'h8);
        chk("post-reset mem L1", rd[0], word_of(BASE + 32'h8));
        for (int i = 0; i < 4; i++) idle();

        // Randomised traffic. Held requests keep their fields until granted.
        for (int n = 0; n < 400; n++) begin
            if (!(req && stall)) begin
                req   = ($urandom_range(0, 3) != 0);
                wen   = 1'($urandom_range(0, 1));
                wdata = $urandom;
                be    = 4'($urandom_range(0, 15));
                sel   = $urandom_range(0, 19);
                if (sel < 16)       add = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
                else if (sel == 16) add = BASE + 32'hFFC;
                else if (sel == 17) add = BASE + 32'h1000 + 32'($urandom_range(0, 255));
                else if (sel == 18) add = BASE - 32'h4;
                else                add = 32'hFFFF_FFFC;
            end
            stall = ($urandom_range(0, 4) == 0);
            step();
        end
        req = 1'b0; stall = 1'b0;
        for (int i = 0; i < 6; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
